// File: rtl/udp_tx_pkg.sv
// Shared types and constants for the UDP transmit scheduler.
package udp_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        START,
        STREAM,
        WAIT_FIN,
        DONE
    } tx_state_t;

    localparam logic [15:0] UDP_HDR_LEN = 16'd8;
    localparam int WORD_BYTES = 4;

    // Payload bytes to 32-bit words, rounded up; 17-bit sum so 0xFFFF cannot wrap.
    function automatic logic [14:0] len_to_words(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'(WORD_BYTES - 1);
        return sum[16:2];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first request strictly after 'last', wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/udp_tx_scheduler.sv
// Shares one UDP encoder among NUM_REQ requesters: arbitrate, latch header,
// sequence clear/start/payload/fin, and hand the result back to the owner.
//
// state    | meaning
// IDLE     | arbitrate; latch grant, header and word count
// CLEAR    | enc_reset pulse
// START    | enc_start pulse, arm fin timer
// STREAM   | owner payload muxed straight to the encoder
// WAIT_FIN | wait for enc_fin or timer terminal count
// DONE     | done pulse to owner, encoder reset, grant released
module udp_tx_scheduler
    import udp_tx_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int FIN_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [16*NUM_REQ-1:0] req_src_port,
    input  logic [16*NUM_REQ-1:0] req_dest_port,
    input  logic [16*NUM_REQ-1:0] req_len,
    input  logic [NUM_REQ-1:0]    req_no_chksum,
    input  logic [32*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]    req_data_av,
    output logic [NUM_REQ-1:0]    grant,
    output logic [NUM_REQ-1:0]    done,
    output logic                  done_err,
    output logic [15:0]           checksum,
    output logic [15:0]           udp_len,
    output logic                  enc_reset,
    output logic                  enc_start,
    output logic                  enc_no_chksum,
    output logic                  enc_data_av,
    output logic [15:0]           enc_src_port,
    output logic [15:0]           enc_dest_port,
    output logic [15:0]           enc_len,
    output logic [31:0]           enc_data,
    input  logic                  enc_fin,
    input  logic [15:0]           enc_checksum,
    input  logic [15:0]           enc_len_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TMR_W = $clog2(FIN_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(FIN_TIMEOUT - 1);

    tx_state_t state, state_nxt;

    logic [15:0] src_arr  [NUM_REQ];
    logic [15:0] dst_arr  [NUM_REQ];
    logic [15:0] len_arr  [NUM_REQ];
    logic [31:0] data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign src_arr[i]  = req_src_port[16*i +: 16];
        assign dst_arr[i]  = req_dest_port[16*i +: 16];
        assign len_arr[i]  = req_len[16*i +: 16];
        assign data_arr[i] = req_data[32*i +: 32];
    end

    logic [NUM_REQ-1:0] arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic [IDX_W-1:0]   owner;
    logic [NUM_REQ-1:0] grant_q;
    logic [15:0]        hdr_src, hdr_dst, hdr_len;
    logic               hdr_no_chksum;
    logic [14:0]        words_left;
    logic [TMR_W-1:0]   fin_tmr;
    logic [15:0]        checksum_q, udp_len_q;
    logic               err_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req  (req),
        .last (owner),
        .en   (state == IDLE),
        .gnt  (arb_gnt),
        .idx  (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        enc_start   = 1'b0;
        enc_data_av = 1'b0;
        enc_data    = '0;
        done        = '0;
        done_err    = 1'b0;
        enc_reset   = reset;
        case (state)
            IDLE:     if (|req) state_nxt = CLEAR;
            CLEAR: begin
                enc_reset = 1'b1;
                state_nxt = START;
            end
            START: begin
                enc_start = 1'b1;
                state_nxt = (words_left != '0) ? STREAM : WAIT_FIN;
            end
            STREAM: begin
                enc_data_av = req_data_av[owner];
                enc_data    = data_arr[owner];
                if (enc_data_av && words_left == 15'd1) state_nxt = WAIT_FIN;
            end
            WAIT_FIN: if (enc_fin || fin_tmr == '0) state_nxt = DONE;
            DONE: begin
                done      = grant_q;
                done_err  = err_q;
                enc_reset = 1'b1;
                state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner         <= IDX_W'(NUM_REQ - 1);
            grant_q       <= '0;
            hdr_src       <= '0;
            hdr_dst       <= '0;
            hdr_len       <= '0;
            hdr_no_chksum <= 1'b0;
            words_left    <= '0;
            fin_tmr       <= '0;
            checksum_q    <= '0;
            udp_len_q     <= '0;
            err_q         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant_q       <= arb_gnt;
                        owner         <= arb_idx;
                        hdr_src       <= src_arr[arb_idx];
                        hdr_dst       <= dst_arr[arb_idx];
                        hdr_len       <= len_arr[arb_idx];
                        hdr_no_chksum <= req_no_chksum[arb_idx];
                        words_left    <= len_to_words(len_arr[arb_idx]);
                    end
                end
                START: fin_tmr <= TMR_LOAD;
                STREAM: begin
                    // Re-arming on every word leaves the timer fresh after the last one.
                    if (enc_data_av) begin
                        words_left <= words_left - 15'd1;
                        fin_tmr    <= TMR_LOAD;
                    end
                end
                WAIT_FIN: begin
                    if (fin_tmr != '0) fin_tmr <= fin_tmr - 1'b1;
                    if (enc_fin) begin
                        checksum_q <= enc_checksum;
                        udp_len_q  <= enc_len_out;
                        err_q      <= 1'b0;
                    end else if (fin_tmr == '0) begin
                        checksum_q <= '0;
                        udp_len_q  <= '0;
                        err_q      <= 1'b1;
                    end
                end
                DONE: grant_q <= '0;
                default: ;
            endcase
        end
    end

    assign grant         = grant_q;
    assign checksum      = checksum_q;
    assign udp_len       = udp_len_q;
    assign enc_src_port  = hdr_src;
    assign enc_dest_port = hdr_dst;
    assign enc_len       = hdr_len;
    assign enc_no_chksum = hdr_no_chksum;

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Directed and randomized bench for udp_tx_scheduler with a packet-level reference model.
module tb_udp_tx_scheduler;
    import udp_tx_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int FT      = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req, req_no_chksum, req_data_av;
    logic [16*NUM_REQ-1:0] req_src_port, req_dest_port, req_len;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    grant, done;
    logic                  done_err;
    logic [15:0]           checksum, udp_len;
    logic                  enc_reset, enc_start, enc_no_chksum, enc_data_av;
    logic [15:0]           enc_src_port, enc_dest_port, enc_len;
    logic [31:0]           enc_data;
    logic                  enc_fin;
    logic [15:0]           enc_checksum, enc_len_out;

    logic [15:0] m_src  [NUM_REQ];
    logic [15:0] m_dst  [NUM_REQ];
    logic [15:0] m_len  [NUM_REQ];
    logic [31:0] m_data [NUM_REQ];

    int checks = 0;
    int errors = 0;
    int rr_last;
    bit av_pat[$];

    always #5 clk = ~clk;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
        assign req_src_port[16*i +: 16]  = m_src[i];
        assign req_dest_port[16*i +: 16] = m_dst[i];
        assign req_len[16*i +: 16]       = m_len[i];
        assign req_data[32*i +: 32]      = m_data[i];
    end

    udp_tx_scheduler #(
        .NUM_REQ     (NUM_REQ),
        .FIN_TIMEOUT (FT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_src_port  (req_src_port),
        .req_dest_port (req_dest_port),
        .req_len       (req_len),
        .req_no_chksum (req_no_chksum),
        .req_data      (req_data),
        .req_data_av   (req_data_av),
        .grant         (grant),
        .done          (done),
        .done_err      (done_err),
        .checksum      (checksum),
        .udp_len       (udp_len),
        .enc_reset     (enc_reset),
        .enc_start     (enc_start),
        .enc_no_chksum (enc_no_chksum),
        .enc_data_av   (enc_data_av),
        .enc_src_port  (enc_src_port),
        .enc_dest_port (enc_dest_port),
        .enc_len       (enc_len),
        .enc_data      (enc_data),
        .enc_fin       (enc_fin),
        .enc_checksum  (enc_checksum),
        .enc_len_out   (enc_len_out)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit next_av();
        if (av_pat.size() > 0) return av_pat.pop_front();
        return 1'($urandom_range(0, 1));
    endfunction

    // Advance to just after the next rising edge and scramble all payload inputs.
    task automatic next_cycle(input int w, input bit use_pat);
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) m_data[i] = $urandom;
        req_data_av = NUM_REQ'($urandom);
        if (w >= 0) req_data_av[w] = use_pat ? next_av() : 1'($urandom_range(0, 1));
    endtask

    function automatic void rand_header(input int i);
        m_src[i]         = 16'($urandom);
        m_dst[i]         = 16'($urandom);
        req_no_chksum[i] = 1'($urandom_range(0, 1));
    endfunction

    // Entered in an IDLE cycle with req already driven; returns in the IDLE cycle after DONE.
    // drop_mode: 0 keep req, 1 drop winner, 2 drop all.
    task automatic do_packet(input int fin_dly, input bit timeout, input int drop_mode);
        int w, nwords, fwd, cyc, lastc, dcyc, budget, dut_cnt;
        logic [NUM_REQ-1:0] exp_g;
        logic [15:0] cks;
        bit av;
        w = -1;
        for (int k = 1; k <= NUM_REQ; k++)
            if (w < 0 && req[(rr_last + k) % NUM_REQ]) w = (rr_last + k) % NUM_REQ;
        if (w < 0) return;
        rr_last = w;
        exp_g = '0;
        exp_g[w] = 1'b1;
        nwords = (int'(m_len[w]) + WORD_BYTES - 1) / WORD_BYTES;
        check("idle_grant", 32'(grant), 32'd0);

        next_cycle(w, 1'b0);
        #2;
        check("clear_grant", 32'(grant), 32'(exp_g));
        check("clear_enc_reset", 32'(enc_reset), 32'd1);
        check("clear_enc_start", 32'(enc_start), 32'd0);
        check("clear_data_av", 32'(enc_data_av), 32'd0);
        check("clear_enc_data", enc_data, 32'd0);
        check("hdr_src", 32'(enc_src_port), 32'(m_src[w]));
        check("hdr_dst", 32'(enc_dest_port), 32'(m_dst[w]));
        check("hdr_len", 32'(enc_len), 32'(m_len[w]));
        check("hdr_nock", 32'(enc_no_chksum), 32'(req_no_chksum[w]));

        next_cycle(w, 1'b0);
        #2;
        check("start_enc_start", 32'(enc_start), 32'd1);
        check("start_enc_reset", 32'(enc_reset), 32'd0);
        check("start_data_av", 32'(enc_data_av), 32'd0);

        cyc = 2;
        lastc = 2;
        fwd = 0;
        budget = 0;
        dut_cnt = 0;
        while (fwd < nwords && budget < 200) begin
            next_cycle(w, 1'b1);
            cyc++;
            budget++;
            #2;
            av = req_data_av[w];
            dut_cnt += int'(enc_data_av);
            check("stream_av", 32'(enc_data_av), 32'(av));
            check("stream_data", enc_data, m_data[w]);
            if (av) begin
                fwd++;
                lastc = cyc;
            end
        end

        cks = 16'($urandom);
        enc_checksum = cks;
        enc_len_out = m_len[w] + UDP_HDR_LEN;
        dcyc = timeout ? lastc + FT + 1 : lastc + fin_dly + 1;
        while (cyc < dcyc) begin
            next_cycle(w, 1'b1);
            cyc++;
            enc_fin = !timeout && (cyc >= lastc + fin_dly);
            #2;
            dut_cnt += int'(enc_data_av);
            if (cyc < dcyc) begin
                check("wait_done", 32'(done), 32'd0);
                check("wait_data_av", 32'(enc_data_av), 32'd0);
                check("wait_enc_data", enc_data, 32'd0);
            end else begin
                check("done_vec", 32'(done), 32'(exp_g));
                check("done_err", 32'(done_err), 32'(timeout));
                check("done_checksum", 32'(checksum), timeout ? 32'd0 : 32'(cks));
                if (!timeout) check("done_udp_len", 32'(udp_len), 32'(m_len[w] + UDP_HDR_LEN));
                check("done_enc_reset", 32'(enc_reset), 32'd1);
                check("done_grant", 32'(grant), 32'(exp_g));
            end
        end
        check("word_count", 32'(dut_cnt), 32'(nwords));

        next_cycle(-1, 1'b0);
        enc_fin = 1'b0;
        if (drop_mode == 1) req[w] = 1'b0;
        if (drop_mode == 2) req = '0;
        #2;
        check("post_grant", 32'(grant), 32'd0);
        check("post_done", 32'(done), 32'd0);
        check("post_enc_reset", 32'(enc_reset), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        req = '0;
        req_no_chksum = '0;
        req_data_av = '0;
        enc_fin = 1'b0;
        enc_checksum = '0;
        enc_len_out = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_src[i] = '0;
            m_dst[i] = '0;
            m_len[i] = '0;
            m_data[i] = '0;
        end
        rr_last = NUM_REQ - 1;

        // Reset values
        repeat (3) @(posedge clk);
        #3;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_done_err", 32'(done_err), 32'd0);
        check("rst_checksum", 32'(checksum), 32'd0);
        check("rst_udp_len", 32'(udp_len), 32'd0);
        check("rst_enc_start", 32'(enc_start), 32'd0);
        check("rst_enc_data_av", 32'(enc_data_av), 32'd0);
        check("rst_enc_reset", 32'(enc_reset), 32'd1);
        reset = 1'b0;

        // Single packet, len 8, fin three cycles after the last word
        rand_header(0);
        m_len[0] = 16'd8;
        req = 2'b01;
        do_packet(3, 1'b0, 2);

        // Round-robin with both requesters continuously pending
        rand_header(0);
        rand_header(1);
        m_len[0] = 16'd4;
        m_len[1] = 16'd4;
        req = 2'b11;
        do_packet(1, 1'b0, 0);
        do_packet(2, 1'b0, 0);
        do_packet(1, 1'b0, 0);
        do_packet(2, 1'b0, 2);

        // Partial last word with gaps in the valid stream
        rand_header(0);
        m_len[0] = 16'd5;
        av_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        req = 2'b01;
        do_packet(1, 1'b0, 2);
        av_pat.delete();

        // Zero-length packet
        rand_header(1);
        m_len[1] = 16'd0;
        req = 2'b10;
        do_packet(2, 1'b0, 2);

        // Timeout with enc_fin never raised
        rand_header(1);
        m_len[1] = 16'($urandom_range(1, 20));
        req = 2'b10;
        do_packet(0, 1'b0 | 1'b1, 2);

        // enc_fin on the same cycle as terminal count: fin wins
        rand_header(0);
        m_len[0] = 16'd4;
        req = 2'b01;
        do_packet(FT, 1'b0, 2);

        // Randomized traffic, winner drops its request after done
        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    rand_header(i);
                    m_len[i] = 16'($urandom_range(0, 24));
                    req[i] = 1'b1;
                end
            end
            if (req == '0) begin
                rand_header(0);
                m_len[0] = 16'($urandom_range(0, 24));
                req[0] = 1'b1;
            end
            do_packet($urandom_range(1, 6), 1'b0, 1);
        end
        req = '0;

        // Reset in the middle of STREAM after one of three words
        next_cycle(-1, 1'b0);
        rand_header(0);
        m_len[0] = 16'd12;
        req = 2'b01;
        next_cycle(0, 1'b0);
        next_cycle(0, 1'b0);
        next_cycle(0, 1'b0);
        req_data_av[0] = 1'b1;
        #2;
        check("rs_first_word", 32'(enc_data_av), 32'd1);
        next_cycle(0, 1'b0);
        reset = 1'b1;
        req_data_av[0] = 1'b0;
        #2;
        check("rs_enc_reset_now", 32'(enc_reset), 32'd1);
        next_cycle(-1, 1'b0);
        req_data_av = '1;
        #2;
        check("rs_grant", 32'(grant), 32'd0);
        check("rs_done", 32'(done), 32'd0);
        check("rs_done_err", 32'(done_err), 32'd0);
        check("rs_checksum", 32'(checksum), 32'd0);
        check("rs_udp_len", 32'(udp_len), 32'd0);
        check("rs_enc_start", 32'(enc_start), 32'd0);
        check("rs_data_av", 32'(enc_data_av), 32'd0);
        check("rs_enc_data", enc_data, 32'd0);
        check("rs_src", 32'(enc_src_port), 32'd0);
        check("rs_dst", 32'(enc_dest_port), 32'd0);
        check("rs_len", 32'(enc_len), 32'd0);
        check("rs_nock", 32'(enc_no_chksum), 32'd0);
        check("rs_enc_reset", 32'(enc_reset), 32'd1);
        reset = 1'b0;
        rr_last = NUM_REQ - 1;
        rand_header(1);
        m_len[1] = 16'd7;
        req = 2'b10;
        do_packet(2, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_tx_scheduler.md
# udp_tx_scheduler

- Shares one `UDP_encoder` instance among `NUM_REQ` requesters.
- Arbitrates round-robin, latches the winner's header fields, and sequences the encoder: clear, start, stream payload, wait for `fin`.
- Returns the checksum and length to the winning requester.
- Sits between the per-socket transmit queues and the encoder/packet FIFO.

## Interface
- `NUM_REQ`, default 2: number of requesters, 2..8.
- `FIN_TIMEOUT`, default 64: cycles allowed between the last forwarded word and `enc_fin`.
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  NUM_REQ  per-requester packet request. Held with its header until `done` for that index.
- `req_src_port`, `req_dest_port`, `req_len`  in  16*NUM_REQ each  packed headers; slice i belongs to requester i.
- `req_no_chksum`  in  NUM_REQ  per-requester checksum disable.
- `req_data`  in  32*NUM_REQ  packed payload words.
- `req_data_av`  in  NUM_REQ  payload word valid.
- `grant`  out  NUM_REQ  one-hot owner of the encoder, or zero.
- `done`  out  NUM_REQ  one-cycle completion pulse to the owner.
- `done_err`  out  1  set together with `done` when the packet ended by timeout.
- `checksum`  out  16  latched `enc_checksum`; valid while `done` is high.
- `udp_len`  out  16  latched `enc_len_out`; valid while `done` is high.
- `enc_reset`, `enc_start`, `enc_no_chksum`, `enc_data_av`  out  1  encoder controls.
- `enc_src_port`, `enc_dest_port`, `enc_len`  out  16  latched header fields.
- `enc_data`  out  32  payload to the encoder.
- `enc_fin`  in  1  encoder finished.
- `enc_checksum`, `enc_len_out`  in  16  encoder results.

## Operation
- States:
  - IDLE
  - CLEAR: `enc_reset`=1 for one cycle.
  - START: `enc_start`=1 for one cycle.
  - STREAM
  - WAIT_FIN
  - DONE: one cycle.
- IDLE → CLEAR when any `req` bit is set. Arbitration in that cycle:
  - Winner is the first set bit scanning from `last+1` upward, wrapping modulo NUM_REQ. `last` resets to NUM_REQ-1.
  - `grant`, the header fields, `words_left` = (`req_len`+3)>>2 and `last` are all latched in that same cycle.
  - `req_len` addition is done at 17 bits; `words_left` is 15 bits.
- CLEAR → START unconditionally.
- START → STREAM if `words_left`≠0, otherwise → WAIT_FIN.
- STREAM:
  - `enc_data_av` = `req_data_av[owner]`; `enc_data` = `req_data[owner]`. Combinational mux, gated by state.
  - Each cycle with `enc_data_av`=1 decrements `words_left`.
  - The word that takes it to 0 is forwarded; the state then moves to WAIT_FIN and the timeout counter clears.
- Outside STREAM: `enc_data_av`=0 and `enc_data`=0. Extra requester words are ignored.
- WAIT_FIN:
  - On `enc_fin`=1: latch `enc_checksum` and `enc_len_out`, go to DONE.
  - When the counter reaches FIN_TIMEOUT: go to DONE with `done_err`=1 and `checksum`=0.
  - `enc_fin` and timeout in the same cycle: `enc_fin` wins, no error.
- DONE:
  - `done[owner]`=1 and `enc_reset`=1 (returns the encoder from its sticky FIN).
  - Clears `grant`, then → IDLE.
- `enc_reset` = `reset` OR (state==CLEAR) OR (state==DONE).
- Requests stay pending across busy periods. A requester that drops `req` mid-packet does not abort the packet; the timeout handles a stalled stream.
- `reset` mid-operation: immediate return to IDLE, all outputs at reset values. No `done` is issued for the aborted packet.

## Timing
- Reset values:
  - `grant`=0, `done`=0, `done_err`=0, `checksum`=0, `udp_len`=0.
  - `enc_start`=0, `enc_data_av`=0, `enc_data`=0, header outputs 0, `enc_reset`=1 while `reset` is high.
- Request to `enc_start`:
  - `req` seen in IDLE at cycle t: `grant` at t+1 (CLEAR), `enc_start` at t+2, STREAM from t+3.
- Payload latency: the scheduler adds 0 cycles; the data path is combinational in STREAM.
- The `done` cycle is one cycle after the `enc_fin` sample.
- Back-to-back: the next arbitration happens in the IDLE cycle after DONE, giving a minimum gap of 1 idle cycle between packets.
- Zero-length packet: START → WAIT_FIN; the encoder emits an 8-byte header and raises `fin`.

## Structure
- Package `udp_tx_pkg`: state enum (IDLE, CLEAR, START, STREAM, WAIT_FIN, DONE), header-length constant 8, word-size constant 4.
- One sub-module, `rr_arbiter`, parameterized by NUM_REQ.
  - Inputs: `req`, `last`, `en`.
  - Outputs: one-hot `gnt` and the winner index.
  - Purely combinational; the pointer register stays in the scheduler.

## Test plan
- Single packet: req0, len=8, two data words, `enc_fin` three cycles after the last word → `grant`=01 at t+1, `enc_start` at t+2, exactly 2 `enc_data_av` pulses, `done[0]` with `checksum`=`enc_checksum` and `udp_len`=16.
- Round-robin: req=11 continuously, len=4 each → grants alternate 01, 10, 01, 10 with 1 idle cycle between packets.
- Partial word and gaps: len=5, `req_data_av` pattern 1,0,0,1,1 → exactly 2 words forwarded; the third valid is ignored with `enc_data_av`=0.
- Zero length: len=0 → no STREAM cycles; `done` after `enc_fin` with `udp_len`=8.
- Timeout: `enc_fin` held at 0 → `done` with `done_err`=1 and `checksum`=0, FIN_TIMEOUT+1 cycles after the last word.
- Reset in STREAM: after 1 of 3 words → outputs return to reset values the next cycle, no `done`; a following request from requester 1 is served normally.
